// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder and its RAM.
package cpu_mem_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned SIZE_DEFAULT = 14;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, read-first, one-cycle registered read.
// clr forces the read register to zero instead of capturing the array.
module ram_sp_sync
  import cpu_mem_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic              clr,
  input  logic [SIZE-1:0]   addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Separate process samples the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// RAM responder for the SimpleCPU port with a streaming program loader that
// holds the CPU in reset until memory has been filled.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [SIZE-1:0]   addr_toRAM,
  input  logic [WORD_W-1:0] data_toRAM,
  output logic [WORD_W-1:0] data_fromRAM,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              load_skip,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic [SIZE:0]     words_loaded
);

  state_e            state;
  logic [SIZE-1:0]   ptr;
  logic              xfer;
  logic              wrap;
  logic              ram_we;
  logic              ram_clr;
  logic [SIZE-1:0]   ram_addr;
  logic [WORD_W-1:0] ram_wdata;

  assign load_ready = ~rst & (state == LOAD);
  assign cpu_hold   = (state == LOAD);
  assign xfer       = load_valid & load_ready;
  assign wrap       = &ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      ptr          <= '0;
      words_loaded <= '0;
    end else if (state == LOAD) begin
      if (xfer) begin
        ptr          <= ptr + SIZE'(1);
        words_loaded <= words_loaded + (SIZE + 1)'(1);
      end
      if ((xfer & (load_last | wrap)) | load_skip) begin
        state <= RUN;
      end
    end
  end

  // Loader owns the RAM port while loading; the CPU is held in reset meanwhile.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_toRAM;
    ram_wdata = data_toRAM;
    if (state == LOAD) begin
      ram_we    = xfer;
      ram_addr  = ptr;
      ram_wdata = load_data;
    end else begin
      ram_we = wrEn & ~rst;
    end
  end

  assign ram_clr = rst | (state == LOAD);

  ram_sp_sync #(
    .SIZE(SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .clr  (ram_clr),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(data_fromRAM)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed loader/RUN scenarios plus random traffic,
// all checked every cycle against a behavioural model of memory and loader.
module tb_cpu_mem_responder;

  localparam int SZ    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [SZ-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_skip;
  logic          load_ready;
  logic          cpu_hold;
  logic [SZ:0]   words_loaded;

  int vectors    = 0;
  int miscompares = 0;

  cpu_mem_responder #(
    .SIZE(SZ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wrEn        (wr_en),
    .addr_toRAM  (addr),
    .data_toRAM  (wdata),
    .data_fromRAM(rdata),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_skip   (load_skip),
    .load_ready  (load_ready),
    .cpu_hold    (cpu_hold),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the load count doubles as the write pointer.
  bit          m_on = 1'b0;
  bit          m_loading;
  int          m_cnt;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_rd;
  bit          m_rd_known;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  always begin
    @(posedge clk);
    if (rst) begin
      m_on       = 1'b1;
      m_loading  = 1'b1;
      m_cnt      = 0;
      m_rd       = '0;
      m_rd_known = 1'b1;
    end else if (m_on) begin
      if (m_loading) begin
        if (load_valid) begin
          m_mem[m_cnt]   = load_data;
          m_known[m_cnt] = 1'b1;
          m_cnt++;
          if (load_last || m_cnt == DEPTH) m_loading = 1'b0;
        end
        if (load_skip) m_loading = 1'b0;
        m_rd       = '0;
        m_rd_known = 1'b1;
      end else begin
        m_rd       = m_mem[addr];
        m_rd_known = m_known[addr];
        if (wr_en) begin
          m_mem[addr]   = wdata;
          m_known[addr] = 1'b1;
        end
      end
    end
    #1;
    if (m_on) begin
      check32("cpu_hold", 32'(cpu_hold), 32'(m_loading));
      check32("load_ready", 32'(load_ready), 32'(m_loading && !rst));
      check32("words_loaded", 32'(words_loaded), m_cnt[31:0]);
      if (m_rd_known) check32("data_fromRAM", rdata, m_rd);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0; load_last = 1'b0; load_skip = 1'b0; wr_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic read_chk(input string name, input int a, input logic [31:0] exp);
    addr = SZ'(a);
    wr_en = 1'b0;
    tick();
    check32(name, rdata, exp);
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; addr = '0; wdata = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; load_skip = 1'b0;
    tick(); tick();
    check32("rst_hold", 32'(cpu_hold), 32'd1);
    check32("rst_ready", 32'(load_ready), 32'd0);
    check32("rst_wl", 32'(words_loaded), 32'd0);
    check32("rst_data", rdata, 32'd0);
    rst = 1'b0;
    tick();
    check32("load_ready_up", 32'(load_ready), 32'd1);

    // Fill all 8 words without load_last: pointer wrap ends the load.
    for (int i = 0; i < DEPTH; i++) begin
      push(fill_word(i), 1'b0);
      if (i == DEPTH - 2) check32("wrap_hold_pre", 32'(cpu_hold), 32'd1);
    end
    check32("wrap_hold", 32'(cpu_hold), 32'd0);
    check32("wrap_wl", 32'(words_loaded), 32'd8);
    check32("model_wrap_cnt", 32'(m_cnt), 32'd8);
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF;
    tick();
    check32("wrap_9th_ready", 32'(load_ready), 32'd0);
    check32("wrap_9th_wl", 32'(words_loaded), 32'd8);
    load_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_chk("wrap_read", i, fill_word(i));

    // Three-word program with load_last on the third.
    do_reset();
    push(32'h1000_0005, 1'b0);
    push(32'h8000_4003, 1'b0);
    check32("prog_hold_pre", 32'(cpu_hold), 32'd1);
    push(32'hDEAD_BEEF, 1'b1);
    check32("prog_wl", 32'(words_loaded), 32'd3);
    check32("prog_hold", 32'(cpu_hold), 32'd0);
    check32("model_prog_cnt", 32'(m_cnt), 32'd3);
    read_chk("prog_r0", 0, 32'h1000_0005);
    read_chk("prog_r1", 1, 32'h8000_4003);
    read_chk("prog_r2", 2, 32'hDEAD_BEEF);
    read_chk("prog_r3_kept", 3, fill_word(3));

    // Same-cycle write and read of address 7 returns the old word.
    addr = 3'd7; wr_en = 1'b1; wdata = 32'h0000_00AA;
    tick();
    check32("rf_old", rdata, fill_word(7));
    read_chk("rf_new", 7, 32'h0000_00AA);

    // load_valid toggling: idle cycles must not advance or write.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = load_valid ? (32'h2000_0000 | 32'(c / 2)) : (32'hBAD0_0000 | 32'(c));
      load_last  = (c == 6);
      tick();
      check32("tog_wl", 32'(words_loaded), 32'(c / 2 + 1));
    end
    load_valid = 1'b0; load_last = 1'b0;
    check32("tog_hold", 32'(cpu_hold), 32'd0);
    for (int i = 0; i < 4; i++) read_chk("tog_read", i, 32'h2000_0000 | 32'(i));
    read_chk("tog_r4_kept", 4, fill_word(4));

    // Reset mid-load, then reload a single word.
    do_reset();
    push(32'h0000_00A0, 1'b0);
    push(32'h0000_00A1, 1'b0);
    rst = 1'b1;
    tick();
    check32("mid_rst_wl", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    push(32'h0000_0055, 1'b1);
    check32("reload_wl", 32'(words_loaded), 32'd1);
    read_chk("reload_r0", 0, 32'h0000_0055);
    read_chk("reload_r1", 1, 32'h0000_00A1);
    read_chk("reload_r2", 2, 32'h2000_0002);

    // Skip in the first LOAD cycle.
    do_reset();
    load_skip = 1'b1;
    tick();
    load_skip = 1'b0;
    check32("skip_hold", 32'(cpu_hold), 32'd0);
    check32("skip_wl", 32'(words_loaded), 32'd0);
    read_chk("skip_r0", 0, 32'h0000_0055);
    read_chk("skip_r1", 1, 32'h0000_00A1);

    // Random traffic; the model process checks every cycle.
    for (int r = 0; r < 60; r++) begin
      rst = 1'b1;
      repeat (1 + $urandom % 2) tick();
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
        rst        = ($urandom % 40 == 0);
        load_valid = $urandom % 2 == 1;
        load_data  = $urandom;
        load_last  = ($urandom % 6 == 0);
        load_skip  = ($urandom % 15 == 0);
        wr_en      = $urandom % 2 == 1;
        addr       = SZ'($urandom % DEPTH);
        wdata      = $urandom;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
